// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: issue-slot requests, flush, multiplier/divider handshake and HI/LO
// readback for the HI/LO controller. The controller side uses the slave modport; the
// execute stage and arithmetic units use the master modport.
interface hilo_muldiv_ctrl_if;
  logic        flush;

  logic        req0_valid;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        grant0;
  logic        grant1;
  logic        stall;
  logic        busy;
  logic [31:0] mf_data;

  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;

  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_done;
  logic [63:0] div_result;

  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output flush,
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  grant0, grant1, stall, busy, mf_data,
    input  mul_start, mul_signed, mul_a, mul_b,
    output mul_result,
    input  div_start, div_signed, div_a, div_b,
    output div_done, div_result,
    input  hi, lo
  );

  modport slave (
    input  flush,
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output grant0, grant1, stall, busy, mf_data,
    output mul_start, mul_signed, mul_a, mul_b,
    input  mul_result,
    output div_start, div_signed, div_a, div_b,
    input  div_done, div_result,
    output hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: owns architectural HI/LO, arbitrates the two issue slots (slot0 first),
// launches the fixed-latency multiplier / variable-latency divider and commits results.
// Optional macro HILO_MF_BYPASS_EN: a winning MFHI/MFLO is granted in a non-flushed
// completion cycle and reads the unit result directly instead of the committed HI/LO.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic               clk,
  input logic               resetn,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam logic [3:0] OpMfhi  = 4'd1;
  localparam logic [3:0] OpMflo  = 4'd2;
  localparam logic [3:0] OpMthi  = 4'd3;
  localparam logic [3:0] OpMtlo  = 4'd4;
  localparam logic [3:0] OpMult  = 4'd5;
  localparam logic [3:0] OpMultu = 4'd6;
  localparam logic [3:0] OpDiv   = 4'd7;
  localparam logic [3:0] OpDivu  = 4'd8;

  typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StDrain} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        v0, v1, win_valid;
  logic [3:0]  win_op;
  logic [31:0] win_a, win_b;
  logic        win_mf, win_mul, win_div;
  logic        mul_done, div_fin;
  logic        idle_go, byp_go, take;
  logic [31:0] src_hi, src_lo;

  // Decode both slots and pick the winner; ops 9..15 count as NONE
  always_comb begin
    v0        = bus.req0_valid && (bus.req0_op >= OpMfhi) && (bus.req0_op <= OpDivu);
    v1        = bus.req1_valid && (bus.req1_op >= OpMfhi) && (bus.req1_op <= OpDivu);
    win_valid = v0 || v1;
    win_op    = v0 ? bus.req0_op : bus.req1_op;
    win_a     = v0 ? bus.req0_a : bus.req1_a;
    win_b     = v0 ? bus.req0_b : bus.req1_b;
    win_mf    = (win_op == OpMfhi) || (win_op == OpMflo);
    win_mul   = (win_op == OpMult) || (win_op == OpMultu);
    win_div   = (win_op == OpDiv) || (win_op == OpDivu);
    mul_done  = (state_q == StMulWait) && (cnt_q == 3'd1);
    div_fin   = (state_q == StDivWait) && bus.div_done;
    idle_go   = (state_q == StIdle) && !bus.flush && win_valid;
    byp_go    = 1'b0;
`ifdef HILO_MF_BYPASS_EN
    byp_go    = !bus.flush && win_valid && win_mf && (mul_done || div_fin);
`endif
    take      = idle_go || byp_go;
  end

  // MF read source: committed HI/LO, or the completing unit's result when bypassing
  always_comb begin
    src_hi = hi_q;
    src_lo = lo_q;
`ifdef HILO_MF_BYPASS_EN
    if (byp_go) begin
      if (mul_done) {src_hi, src_lo} = bus.mul_result;
      else          {src_hi, src_lo} = bus.div_result;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (idle_go && win_mul)      state_d = StMulWait;
        else if (idle_go && win_div) state_d = StDivWait;
      end
      StMulWait: begin
        if (bus.flush || (cnt_q == 3'd1)) state_d = StIdle;
      end
      StDivWait: begin
        // A flush alone cannot cancel the divider; wait for its done in DRAIN
        if (bus.div_done)   state_d = StIdle;
        else if (bus.flush) state_d = StDrain;
      end
      StDrain: begin
        if (bus.div_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // HI/LO writes and multiplier countdown
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (idle_go) begin
          if (win_op == OpMthi) hi_d = win_a;
          if (win_op == OpMtlo) lo_d = win_a;
          if (win_mul)          cnt_d = 3'(MUL_LAT);
        end
      end
      StMulWait: begin
        if (bus.flush) begin
          cnt_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) {hi_d, lo_d} = bus.mul_result;
        end
      end
      StDivWait: begin
        if (bus.div_done && !bus.flush) {hi_d, lo_d} = bus.div_result;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs: grants, stall, MF data and launch-cycle-only unit operands
  always_comb begin
    bus.grant0     = take && v0;
    bus.grant1     = take && !v0;
    bus.stall      = (v0 && !(take && v0)) || (v1 && !(take && !v0));
    bus.busy       = (state_q != StIdle);
    bus.mf_data    = '0;
    if (take && (win_op == OpMfhi)) bus.mf_data = src_hi;
    if (take && (win_op == OpMflo)) bus.mf_data = src_lo;
    bus.mul_start  = idle_go && win_mul;
    bus.mul_signed = bus.mul_start && (win_op == OpMult);
    bus.mul_a      = bus.mul_start ? win_a : '0;
    bus.mul_b      = bus.mul_start ? win_b : '0;
    bus.div_start  = idle_go && win_div;
    bus.div_signed = bus.div_start && (win_op == OpDiv);
    bus.div_a      = bus.div_start ? win_a : '0;
    bus.div_b      = bus.div_start ? win_b : '0;
    bus.hi         = hi_q;
    bus.lo         = lo_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed scenarios with literal expectations, then random traffic
// against a cycle-level behavioural model (timestamps instead of counters).
module tb_hilo_muldiv_ctrl;
  localparam int unsigned MUL_LAT = 2;
  localparam int ModeIdle  = 0;
  localparam int ModeMul   = 1;
  localparam int ModeDiv   = 2;
  localparam int ModeDrain = 3;
  localparam logic [3:0] OpMfhi = 4'd1, OpMflo = 4'd2, OpMthi = 4'd3, OpMtlo = 4'd4;
  localparam logic [3:0] OpMult = 4'd5, OpMultu = 4'd6, OpDiv = 4'd7, OpDivu = 4'd8;

  logic clk = 1'b0;
  logic resetn;
  hilo_muldiv_ctrl_if bus ();

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit stray_en = 1'b0;

  // Model state and bench-side arithmetic units
  int          m_mode = ModeIdle;
  logic [31:0] m_hi = '0, m_lo = '0;
  int          m_mul_end = 0;
  logic [63:0] m_mul_prod = '0, m_div_res = '0;
  bit          div_busy = 1'b0;
  int          div_delay = 0;
  int          div_fixed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mul_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      u = 64'(p);
    end else begin
      u = {32'd0, a} * {32'd0, b};
    end
    return u;
  endfunction

  // {remainder, quotient}; divide by zero returns an arbitrary pattern
  function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic model_step();
    bit          v0, v1, win, take, byp, is_mf, cm, cd, ms, ds;
    logic [3:0]  op;
    logic [31:0] a, b, e_mf;
    logic [63:0] fwd;
    v0    = bus.req0_valid && (bus.req0_op inside {[4'd1:4'd8]});
    v1    = bus.req1_valid && (bus.req1_op inside {[4'd1:4'd8]});
    win   = v0 || v1;
    op    = v0 ? bus.req0_op : bus.req1_op;
    a     = v0 ? bus.req0_a : bus.req1_a;
    b     = v0 ? bus.req0_b : bus.req1_b;
    is_mf = (op == OpMfhi) || (op == OpMflo);
    cm    = (m_mode == ModeMul) && (cyc == m_mul_end);
    cd    = (m_mode == ModeDiv) && bus.div_done;
    take  = win && !bus.flush && (m_mode == ModeIdle);
    byp   = 1'b0;
`ifdef HILO_MF_BYPASS_EN
    byp   = win && !bus.flush && is_mf && (cm || cd);
`endif
    take  = take || byp;
    ms    = take && (op == OpMult || op == OpMultu);
    ds    = take && (op == OpDiv || op == OpDivu);
    fwd   = cm ? m_mul_prod : m_div_res;
    e_mf  = '0;
    if (take && op == OpMfhi) e_mf = byp ? fwd[63:32] : m_hi;
    if (take && op == OpMflo) e_mf = byp ? fwd[31:0] : m_lo;

    chk("ctrl",
        128'({bus.grant0, bus.grant1, bus.stall, bus.busy,
              bus.mul_start, bus.mul_signed, bus.div_start, bus.div_signed}),
        128'({take && v0, take && !v0, (v0 && !(take && v0)) || (v1 && !(take && !v0)),
              m_mode != ModeIdle, ms, ms && op == OpMult, ds, ds && op == OpDiv}));
    chk("mf_data", 128'(bus.mf_data), 128'(e_mf));
    chk("operands", {bus.mul_a, bus.mul_b, bus.div_a, bus.div_b},
        {ms ? a : 32'd0, ms ? b : 32'd0, ds ? a : 32'd0, ds ? b : 32'd0});
    chk("hilo", 128'({bus.hi, bus.lo}), 128'({m_hi, m_lo}));

    case (m_mode)
      ModeIdle: begin
        if (take && op == OpMthi) m_hi = a;
        if (take && op == OpMtlo) m_lo = a;
        if (ms) begin
          m_mode     = ModeMul;
          m_mul_end  = cyc + int'(MUL_LAT);
          m_mul_prod = mul_ref(op == OpMult, a, b);
        end
        if (ds) begin
          m_mode    = ModeDiv;
          m_div_res = div_ref(op == OpDiv, a, b);
          div_busy  = 1'b1;
          div_delay = (div_fixed != 0) ? div_fixed : int'($urandom_range(1, 6));
        end
      end
      ModeMul: begin
        if (bus.flush) m_mode = ModeIdle;
        else if (cm) begin
          {m_hi, m_lo} = m_mul_prod;
          m_mode = ModeIdle;
        end
      end
      ModeDiv: begin
        if (bus.div_done) begin
          if (!bus.flush) {m_hi, m_lo} = m_div_res;
          m_mode = ModeIdle;
        end else if (bus.flush) begin
          m_mode = ModeDrain;
        end
      end
      default: begin
        if (bus.div_done) m_mode = ModeIdle;
      end
    endcase
  endtask

  // Single compare process: mid-cycle, inputs and outputs are settled
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_mode = ModeIdle;
        m_hi   = '0;
        m_lo   = '0;
      end else if (chk_en) begin
        model_step();
      end
      cyc++;
    end
  end

  // Bench multiplier/divider: result only correct on the cycle it is due
  task automatic drive_units();
    bus.div_done   = 1'b0;
    bus.div_result = {$urandom, $urandom};
    bus.mul_result = (m_mode == ModeMul && cyc == m_mul_end) ? m_mul_prod : {$urandom, $urandom};
    if (div_busy) begin
      div_delay--;
      if (div_delay == 0) begin
        bus.div_done   = 1'b1;
        bus.div_result = m_div_res;
        div_busy       = 1'b0;
      end
    end else if (stray_en && (m_mode == ModeIdle || m_mode == ModeMul) &&
                 $urandom_range(0, 15) == 0) begin
      bus.div_done = 1'b1;
    end
  endtask

  task automatic idle_reqs();
    bus.flush = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    drive_units();
    idle_reqs();
  endtask

  task automatic req0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
  endtask

  function automatic logic [3:0] rand_op();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 18) return 4'(r % 9);
    return 4'($urandom_range(9, 15));
  endfunction

  function automatic logic [31:0] rand_opnd();
    if ($urandom_range(0, 7) == 0) return 32'd0;
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
    return $urandom;
  endfunction

  task automatic rand_req();
    bus.req0_valid = ($urandom_range(0, 9) < 6);
    bus.req0_op    = rand_op();
    bus.req0_a     = rand_opnd();
    bus.req0_b     = rand_opnd();
    bus.req1_valid = ($urandom_range(0, 9) < 6);
    bus.req1_op    = rand_op();
    bus.req1_a     = rand_opnd();
    bus.req1_b     = rand_opnd();
    bus.flush      = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    idle_reqs();
    bus.mul_result = '0;
    bus.div_done   = 1'b0;
    bus.div_result = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hilo", 128'({bus.hi, bus.lo}), 128'd0);
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_outs", 128'({bus.grant0, bus.grant1, bus.stall, bus.mul_start, bus.div_start}),
        128'd0);
    resetn = 1'b1;
    chk_en = 1'b1;

    // MTHI on slot0
    next_cycle(); req0(OpMthi, 32'h1234_5678, 32'd0); #1;
    chk("mthi_grant", 128'(bus.grant0), 128'd1);
    next_cycle(); #1;
    chk("mthi_hilo", 128'({bus.hi, bus.lo}), 128'({32'h1234_5678, 32'd0}));

    // Both slots: slot0 wins, slot1 stalls then reads the new LO
    next_cycle(); req0(OpMtlo, 32'hA, 32'd0);
    bus.req1_valid = 1'b1; bus.req1_op = OpMflo; #1;
    chk("prio_grants", 128'({bus.grant0, bus.grant1, bus.stall}), 128'(3'b101));
    next_cycle(); bus.req1_valid = 1'b1; bus.req1_op = OpMflo; #1;
    chk("slot1_grant", 128'(bus.grant1), 128'd1);
    chk("slot1_mflo", 128'(bus.mf_data), 128'(32'hA));

    // MULT -1 x 2
    next_cycle(); req0(OpMult, 32'hFFFF_FFFF, 32'd2); #1;
    chk("mult_start", 128'({bus.mul_start, bus.mul_signed, bus.mul_a, bus.mul_b}),
        128'({2'b11, 32'hFFFF_FFFF, 32'd2}));
    next_cycle(); #1; chk("mult_busy1", 128'(bus.busy), 128'd1);
    next_cycle(); #1; chk("mult_busy2", 128'(bus.busy), 128'd1);
    next_cycle(); #1;
    chk("mult_idle", 128'(bus.busy), 128'd0);
    chk("mult_hilo", 128'({bus.hi, bus.lo}), 128'({32'hFFFF_FFFF, 32'hFFFF_FFFE}));

    // MULTU same operands
    next_cycle(); req0(OpMultu, 32'hFFFF_FFFF, 32'd2);
    next_cycle(); next_cycle(); next_cycle(); #1;
    chk("multu_hilo", 128'({bus.hi, bus.lo}), 128'({32'd1, 32'hFFFF_FFFE}));

    // DIV 7/2, done 5 cycles later; MFLO waits
    div_fixed = 5;
    next_cycle(); req0(OpDiv, 32'd7, 32'd2); #1;
    chk("div_start", 128'({bus.div_start, bus.div_signed}), 128'(2'b11));
    for (int k = 1; k <= 4; k++) begin
      next_cycle(); req0(OpMflo, 32'd0, 32'd0); #1;
      chk("div_wait_stall", 128'({bus.grant0, bus.stall}), 128'(2'b01));
    end
    next_cycle(); req0(OpMflo, 32'd0, 32'd0); #1;
`ifdef HILO_MF_BYPASS_EN
    chk("div_byp_grant", 128'({bus.grant0, bus.mf_data}), 128'({1'b1, 32'd3}));
    next_cycle(); #1;
`else
    chk("div_done_stall", 128'({bus.grant0, bus.stall}), 128'(2'b01));
    next_cycle(); req0(OpMflo, 32'd0, 32'd0); #1;
    chk("div_late_grant", 128'({bus.grant0, bus.mf_data}), 128'({1'b1, 32'd3}));
`endif
    chk("div_hilo", 128'({bus.hi, bus.lo}), 128'({32'd1, 32'd3}));

    // DIVU 99/10 -> {9,9}, flushed two cycles after launch: result discarded
    next_cycle(); req0(OpDivu, 32'd99, 32'd10);
    next_cycle();
    next_cycle(); bus.flush = 1'b1; #1;
    chk("flush_busy", 128'(bus.busy), 128'd1);
    next_cycle(); req0(OpMthi, 32'h55, 32'd0); #1;
    chk("drain_block", 128'({bus.busy, bus.grant0, bus.stall}), 128'(3'b101));
    next_cycle();
    next_cycle(); #1;
    chk("drain_done", 128'({bus.busy, bus.div_done}), 128'(2'b11));
    next_cycle(); #1;
    chk("drain_idle", 128'(bus.busy), 128'd0);
    chk("drain_hilo", 128'({bus.hi, bus.lo}), 128'({32'd1, 32'd3}));
    div_fixed = 0;

    // Reset during MUL_WAIT, then a stale div_done
    next_cycle(); req0(OpMultu, 32'd3, 32'd5);
    next_cycle(); #1;
    chk("rst_pre_busy", 128'(bus.busy), 128'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rst_async", 128'({bus.busy, bus.hi, bus.lo}), 128'd0);
    next_cycle();
    resetn = 1'b1;
    bus.div_done = 1'b1;
    #1;
    chk("stale_done", 128'({bus.busy, bus.hi, bus.lo}), 128'd0);
    next_cycle(); #1;
    chk("stale_after", 128'({bus.busy, bus.hi, bus.lo}), 128'd0);

    // Random traffic against the model
    stray_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rand_req();
    end
    stray_en = 1'b0;
    repeat (10) next_cycle();
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Controller that owns the architectural HI/LO registers and sequences all HI/LO-class instructions from the two issue slots. It arbitrates slot0/slot1 for the single HI/LO resource, launches the fixed-latency multiplier and the variable-latency divider, and commits their 64-bit results. It sits in the execute stage beside the ALUs and returns MFHI/MFLO data to the issuing slot.

## Interface

- MUL_LAT, 2, multiplier latency in cycles from `mul_start` to a valid `mul_result` (1..7)
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills requests and in-flight ops
- reqN_valid  in  1  (N=0,1) slot N presents a HI/LO op
- reqN_op  in  4  (N=0,1) 0 NONE, 1 MFHI, 2 MFLO, 3 MTHI, 4 MTLO, 5 MULT, 6 MULTU, 7 DIV, 8 DIVU; 9..15 treated as NONE
- reqN_a, reqN_b  in  32  (N=0,1) operands; MT uses a
- grantN  out  1  (N=0,1) op of slot N accepted this cycle
- stall  out  1  a valid non-NONE request is not granted this cycle
- busy  out  1  state != IDLE
- mf_data  out  32  MFHI/MFLO result, valid with the grant
- mul_start  out  1  one-cycle launch pulse
- mul_signed  out  1  MULT vs MULTU
- mul_a, mul_b  out  32  multiplier operands
- mul_result  in  64  {HI,LO} product
- div_start  out  1  one-cycle launch pulse
- div_signed  out  1  DIV vs DIVU
- div_a, div_b  out  32  dividend, divisor
- div_done  in  1  one-cycle completion pulse
- div_result  in  64  [63:32] remainder→HI, [31:0] quotient→LO
- hi, lo  out  32  architectural HI/LO

## Operation

- Arbitration: at most one grant per cycle; fixed priority slot0 (older) over slot1. Slot1 granted only if slot0 presents no valid op. Ungranted valid ops raise `stall`.
- States: IDLE, MUL_WAIT, DIV_WAIT, DRAIN.
- IDLE: grant the winner unless `flush`.
  - MFHI/MFLO: `mf_data` = hi/lo combinationally.
  - MTHI/MTLO: write hi/lo with `reqN_a` at clock edge.
  - MULT/MULTU: pulse `mul_start`, load counter = MUL_LAT, → MUL_WAIT.
  - DIV/DIVU: pulse `div_start`, → DIV_WAIT.
- MUL_WAIT: counter decrements each cycle; completion cycle is counter==1; commit {hi,lo}=`mul_result` at its edge, → IDLE.
- DIV_WAIT: on `div_done` commit {hi,lo}=`div_result`, → IDLE.
- All requests (including MT) are not granted while busy, except the bypass case below.
- Flush: in IDLE, no grant. In MUL_WAIT, → IDLE next cycle, no commit. In DIV_WAIT, → DRAIN (divider cannot be cancelled). `div_done` during DRAIN discards the result and → IDLE. `flush` coincident with a completion discards that result.
- Divide by zero: commit whatever `div_result` returns; no exception.
- Operand outputs are driven only in the launch cycle and are 0 otherwise.

## Timing

- Reset: hi=lo=0, state IDLE, counter 0, all outputs 0.
- MF: zero-latency; data in the grant cycle.
- MT: new value visible on hi/lo in cycle T+1.
- MUL launched in cycle T: completion cycle is T+MUL_LAT, hi/lo updated at T+MUL_LAT+1, IDLE at T+MUL_LAT+1.
- DIV: hi/lo updated in the cycle after `div_done`. `div_done` in the launch cycle is ignored.
- A new op can launch in the first IDLE cycle after completion.
- Reset mid-operation: immediate return to IDLE; late `div_done` after reset is ignored because the state is IDLE.

## Configuration

- HILO_MF_BYPASS_EN defined: in a non-flushed completion cycle (MUL counter==1 or DIV `div_done`), a winning MFHI/MFLO is granted. `mf_data` is forwarded from `mul_result`/`div_result` [63:32]/[31:0].
- Undefined: MF stalls until the following IDLE cycle and reads committed hi/lo.

## Test plan

- Reset, then MTHI a=0x12345678 on slot0 → grant0=1; next cycle hi=0x12345678, lo=0.
- Both slots valid: slot0 MTLO 0xA, slot1 MFLO → grant0=1, grant1=0, stall=1; next cycle slot1 granted, mf_data=0xA.
- MULT 0xFFFFFFFF×2 with MUL_LAT=2 → busy 2 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU of the same operands → hi=1, lo=0xFFFFFFFE.
- DIV 7/2 with `div_done` 5 cycles later, result {1,3} → hi=1, lo=3; an MFLO waiting during DIV_WAIT returns 3. With the macro it is granted in the `div_done` cycle; without it, one cycle later.
- DIV launched, `flush` 2 cycles later → DRAIN. `div_done` {9,9} is discarded, hi/lo unchanged, IDLE the next cycle.
- `resetn` low during MUL_WAIT → hi=lo=0, busy=0 immediately; a stale `div_done` pulse afterward has no effect.
